// File: rtl/inputconditioner_array.sv
// inputconditioner_array
//   Debounces and synchronizes CHANNELS independent noisy inputs. Each channel
//   has its own SYNCSTAGES-deep synchronizer, COUNTERWIDTH-bit debounce
//   counter, registered conditioned level and one-cycle edge pulses. A sticky
//   per-channel fault flag forces that channel's negativeedge high.
//
//   Ports
//     clk             rising-edge clock for all state
//     reset           synchronous, active-high; clears all state
//     noisysignal     asynchronous noisy inputs, one bit per channel
//     waittime        debounce delay in cycles, shared, sampled every cycle
//     faultmask       per-channel fault injection enable
//     conditioned     debounced, synchronized level per channel
//     positiveedge    one-cycle pulse on rising edge of conditioned
//     negativeedge    one-cycle pulse on falling edge, forced 1 while faulted
//     faulted         sticky per-channel fault flag
//     anypositiveedge OR of positiveedge
//     anynegativeedge OR of negativeedge
module inputconditioner_array #(
   parameter int CHANNELS     = 4,
   parameter int COUNTERWIDTH = 3,
   parameter int SYNCSTAGES   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CHANNELS-1:0]     noisysignal,
   input  logic [COUNTERWIDTH-1:0] waittime,
   input  logic [CHANNELS-1:0]     faultmask,
   output logic [CHANNELS-1:0]     conditioned,
   output logic [CHANNELS-1:0]     positiveedge,
   output logic [CHANNELS-1:0]     negativeedge,
   output logic [CHANNELS-1:0]     faulted,
   output logic                    anypositiveedge,
   output logic                    anynegativeedge
);

   // sync_chain[i][0] samples the pin; the top bit is the synchronized level
   logic [SYNCSTAGES-1:0]   sync_chain [CHANNELS];
   logic [COUNTERWIDTH-1:0] counter    [CHANNELS];
   logic [CHANNELS-1:0]     pos_pulse;
   logic [CHANNELS-1:0]     neg_pulse;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            sync_chain[i] <= '0;
            counter[i]    <= '0;
         end
         conditioned <= '0;
         pos_pulse   <= '0;
         neg_pulse   <= '0;
         faulted     <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            sync_chain[i] <= {sync_chain[i][SYNCSTAGES-2:0], noisysignal[i]};
            pos_pulse[i]  <= 1'b0;
            neg_pulse[i]  <= 1'b0;

            if (conditioned[i] == sync_chain[i][SYNCSTAGES-1]) begin
               counter[i] <= '0;
            end else if (counter[i] >= waittime) begin
               // ">=" lets a mid-count drop of waittime commit immediately
               // and keeps the counter from ever wrapping
               counter[i]     <= '0;
               conditioned[i] <= sync_chain[i][SYNCSTAGES-1];
               pos_pulse[i]   <= sync_chain[i][SYNCSTAGES-1];
               neg_pulse[i]   <= ~sync_chain[i][SYNCSTAGES-1];
            end else begin
               counter[i] <= counter[i] + 1'b1;
            end

            if (faultmask[i]) begin
               faulted[i] <= 1'b1;
            end
         end
      end
   end

   // Fault override is applied on the output side so the debounce state and
   // the registered falling-edge pulse are left untouched by a fault.
   always_comb begin
      positiveedge    = pos_pulse;
      negativeedge    = neg_pulse | faulted;
      anypositiveedge = |positiveedge;
      anynegativeedge = |negativeedge;
   end

endmodule

// File: tb/tb_inputconditioner_array.sv
module tb_inputconditioner_array;

   localparam int CH = 4;
   localparam int W  = 3;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [CH-1:0] noisysignal = '0;
   logic [W-1:0]  waittime = 3'd3;
   logic [CH-1:0] faultmask = '0;
   logic [CH-1:0] conditioned, positiveedge, negativeedge, faulted;
   logic          anypositiveedge, anynegativeedge;

   int checks = 0;
   int passed = 0;

   inputconditioner_array #(
      .CHANNELS    (CH),
      .COUNTERWIDTH(W),
      .SYNCSTAGES  (SS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .noisysignal    (noisysignal),
      .waittime       (waittime),
      .faultmask      (faultmask),
      .conditioned    (conditioned),
      .positiveedge   (positiveedge),
      .negativeedge   (negativeedge),
      .faulted        (faulted),
      .anypositiveedge(anypositiveedge),
      .anynegativeedge(anynegativeedge)
   );

   always #5 clk = ~clk;

   // Reference model: the synchronized level is simply the pin value sampled
   // SS edges ago (kept as a history of samples since reset); a channel
   // commits once the mismatch has already lasted waittime edges.
   logic [CH-1:0] in_hist [$];
   logic [CH-1:0] m_cond = '0, m_pos = '0, m_neg = '0, m_flt = '0;
   int            m_run [CH];

   task automatic model_step();
      logic [CH-1:0] s;
      if (reset) begin
         m_cond = '0; m_pos = '0; m_neg = '0; m_flt = '0;
         for (int c = 0; c < CH; c++) m_run[c] = 0;
         in_hist.delete();
         return;
      end
      s = (in_hist.size() >= SS) ? in_hist[in_hist.size() - SS] : '0;
      m_pos = '0;
      m_neg = '0;
      for (int c = 0; c < CH; c++) begin
         if (s[c] == m_cond[c]) m_run[c] = 0;
         else if (m_run[c] >= int'(waittime)) begin
            m_run[c]  = 0;
            m_cond[c] = s[c];
            m_pos[c]  = s[c];
            m_neg[c]  = ~s[c];
         end else m_run[c] = m_run[c] + 1;
      end
      m_flt = m_flt | faultmask;
      in_hist.push_back(noisysignal);
      if (in_hist.size() > SS + 2) void'(in_hist.pop_front());
   endtask

   function automatic logic [31:0] model_vec();
      logic [CH-1:0] n;
      n = m_neg | m_flt;
      return 32'({m_cond, m_pos, n, m_flt, |m_pos, |n});
   endfunction

   function automatic logic [31:0] dut_vec();
      return 32'({conditioned, positiveedge, negativeedge, faulted,
                  anypositiveedge, anynegativeedge});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic tick(input string name, input bit use_model);
      @(posedge clk);
      model_step();
      #1;
      if (use_model) check(name, dut_vec(), model_vec());
   endtask

   task automatic do_reset();
      reset = 1'b1; noisysignal = '0; faultmask = '0;
      tick("reset", 1'b1);
      reset = 1'b0;
   endtask

   typedef struct {
      logic          rst;
      logic [CH-1:0] noisy;
      logic [W-1:0]  wt;
      logic [CH-1:0] fm;
      logic [CH-1:0] cond, pos, neg, flt;
      logic          anyp, anyn;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int pulses;
      bit saw_pulse;
      logic vals [32];

      // Single rising input on channel 0, waittime 3: commit at edge 6
      tbl[0] = '{1'b1, 4'h0, 3'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b0, 4'h1, 3'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 4'h1, 3'd3, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};

      for (int i = 0; i < 9; i++) begin
         reset = tbl[i].rst; noisysignal = tbl[i].noisy;
         waittime = tbl[i].wt; faultmask = tbl[i].fm;
         tick("table", 1'b0);
         check($sformatf("table row %0d", i), dut_vec(),
               32'({tbl[i].cond, tbl[i].pos, tbl[i].neg, tbl[i].flt, tbl[i].anyp, tbl[i].anyn}));
      end

      // Bounce: 3-cycle pulse rejected, 4-cycle pulse accepted then released
      waittime = 3'd3; do_reset();
      saw_pulse = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         noisysignal[1] = (t <= 3);
         tick("bounce3", 1'b1);
         if (positiveedge[1] || negativeedge[1] || conditioned[1]) saw_pulse = 1'b1;
      end
      check("bounce3 no change", 32'(saw_pulse), 32'd0);
      for (int t = 1; t <= 12; t++) begin
         noisysignal[1] = (t <= 4);
         tick("pulse4", 1'b1);
         if (t == 6) check("pulse4 rise", 32'({conditioned[1], positiveedge[1]}), 32'b11);
         if (t == 9) check("pulse4 hold", 32'({conditioned[1], negativeedge[1]}), 32'b10);
         if (t == 10) check("pulse4 fall", 32'({conditioned[1], negativeedge[1]}), 32'b01);
      end

      // waittime 0: conditioned follows input two edges later
      waittime = 3'd0; do_reset();
      pulses = 0;
      for (int t = 1; t <= 24; t++) begin
         noisysignal[2] = (((t - 1) / 4) % 2 == 0);
         vals[t] = noisysignal[2];
         tick("nodebounce", 1'b1);
         if (positiveedge[2]) pulses++;
         if (negativeedge[2]) pulses++;
         if (t >= 3) check("nodebounce delay", 32'(conditioned[2]), 32'(vals[t-2]));
      end
      check("nodebounce pulse count", 32'(pulses), 32'd6);

      // Fault on channel 3: sticky, forces negativeedge, debounce unaffected
      waittime = 3'd3; do_reset();
      faultmask[3] = 1'b1;
      tick("fault set", 1'b1);
      faultmask[3] = 1'b0;
      check("fault flag", 32'({faulted[3], negativeedge[3], anynegativeedge}), 32'b111);
      noisysignal[3] = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick("fault run", 1'b1);
         if (t == 6)
            check("fault rise", 32'({conditioned[3], positiveedge[3], negativeedge[3], faulted[3]}), 32'b1111);
      end
      check("fault others", 32'({faulted[2:0], negativeedge[2:0]}), 32'd0);
      do_reset();
      check("fault cleared", 32'({faulted[3], negativeedge[3]}), 32'b00);

      // waittime lowered mid-count commits at the next edge
      waittime = 3'd7; do_reset();
      noisysignal[0] = 1'b1;
      for (int t = 1; t <= 7; t++) tick("wtchange count", 1'b1);
      check("wtchange before", 32'(conditioned[0]), 32'd0);
      waittime = 3'd2;
      tick("wtchange commit", 1'b1);
      check("wtchange after", 32'({conditioned[0], positiveedge[0]}), 32'b11);

      // Reset mid-count discards pending transition
      waittime = 3'd3; do_reset();
      noisysignal = '1;
      for (int t = 1; t <= 4; t++) tick("midreset count", 1'b1);
      reset = 1'b1;
      for (int t = 1; t <= 2; t++) begin
         tick("midreset hold", 1'b1);
         check("midreset zero", dut_vec(), 32'd0);
      end
      reset = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         tick("midreset after", 1'b1);
         if (t == 5) check("midreset still low", 32'(conditioned), 32'd0);
         if (t == 6) check("midreset rise", 32'({conditioned, positiveedge, anypositiveedge}), 32'h1ff);
      end

      // Randomized run against the model
      do_reset();
      for (int t = 0; t < 1500; t++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 29) == 0) waittime = 3'($urandom_range(0, 7));
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 5) == 0) noisysignal[c] = ~noisysignal[c];
            faultmask[c] = ($urandom_range(0, 399) == 0);
         end
         tick("random", 1'b1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
